// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: in-order FIFO of committed stores feeding the DCache write arbiter
// Ports:
//   St_Enq_*          enqueue side from LSU commit (Valid/Ready handshake)
//   DCache_WrReq_*    head-entry write request, Valid held level until Done
//   DCache_WrResp_*   Done pulse pops the head; Ready gates starting a new issue
//   Ld_Chk_Paddr/Hit  8-byte granule RAW check against every pending entry
//   Sb_Empty/Sb_Count drain status and occupancy
module dcache_store_buffer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 56,
  parameter int DATA_W  = 64,
  parameter int DTYPE_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       St_Enq_Valid,
  input  logic [ADDR_W-1:0]          St_Enq_Paddr,
  input  logic [DTYPE_W-1:0]         St_Enq_DataType,
  input  logic [DATA_W-1:0]          St_Enq_Data,
  output logic                       St_Enq_Ready,
  output logic                       DCache_WrReq_Valid,
  output logic [ADDR_W-1:0]          DCache_WrReq_Paddr,
  output logic [DTYPE_W-1:0]         DCache_WrReq_DataType,
  output logic [DATA_W-1:0]          DCache_WrReq_Data,
  input  logic                       DCache_WrResp_Done,
  input  logic                       DCache_WrResp_Ready,
  input  logic [ADDR_W-1:0]          Ld_Chk_Paddr,
  output logic                       Ld_Chk_Hit,
  output logic                       Sb_Empty,
  output logic [$clog2(DEPTH):0]     Sb_Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RETIRE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0]  paddr_q [DEPTH];
  logic [DTYPE_W-1:0] dtype_q [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               enq, pop, issue;
  logic               unused_low_bits;
  assign unused_low_bits = ^Ld_Chk_Paddr[2:0];
  assign St_Enq_Ready = count != CW'(DEPTH);
  assign enq   = St_Enq_Valid && St_Enq_Ready;
  assign issue = state == ISSUE;
  assign pop   = issue && DCache_WrResp_Done;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (count != '0 && DCache_WrResp_Ready) ? ISSUE : IDLE;
      ISSUE:   state_nxt = DCache_WrResp_Done ? RETIRE : ISSUE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // enq and pop never hit the same slot: enq needs not-full, pop needs a valid head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      state <= state_nxt;
      count <= count + CW'(enq) - CW'(pop);
      if (enq) begin
        wr_ptr        <= wr_ptr + PW'(1);
        vld_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        vld_q[rd_ptr] <= 1'b0;
      end
    end
  end
  // payload needs no reset: vld_q and the ISSUE gate hide stale contents
  always_ff @(posedge clk) begin
    if (enq) begin
      paddr_q[wr_ptr] <= St_Enq_Paddr;
      dtype_q[wr_ptr] <= St_Enq_DataType;
      data_q[wr_ptr]  <= St_Enq_Data;
    end
  end
  always_comb begin
    Ld_Chk_Hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && paddr_q[i][ADDR_W-1:3] == Ld_Chk_Paddr[ADDR_W-1:3]) Ld_Chk_Hit = 1'b1;
  end
  assign DCache_WrReq_Valid    = issue;
  assign DCache_WrReq_Paddr    = issue ? paddr_q[rd_ptr] : '0;
  assign DCache_WrReq_DataType = issue ? dtype_q[rd_ptr] : '0;
  assign DCache_WrReq_Data     = issue ? data_q[rd_ptr]  : '0;
  assign Sb_Empty = count == '0 && state == IDLE;
  assign Sb_Count = count;
endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb_dcache_store_buffer: directed vector table plus hand-written multi-cycle sequences
module tb_dcache_store_buffer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        ev = 0;
  logic [55:0] pa = 0;
  logic [2:0]  dt = 0;
  logic [63:0] d = 0;
  logic        rdy;
  logic        valid;
  logic [55:0] qa;
  logic [2:0]  qdt;
  logic [63:0] qd;
  logic        done = 0;
  logic        wrr = 1;
  logic [55:0] ck = 0;
  logic        hit;
  logic        emp;
  logic [3:0]  cnt;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dcache_store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .St_Enq_Valid(ev), .St_Enq_Paddr(pa), .St_Enq_DataType(dt), .St_Enq_Data(d),
    .St_Enq_Ready(rdy),
    .DCache_WrReq_Valid(valid), .DCache_WrReq_Paddr(qa), .DCache_WrReq_DataType(qdt),
    .DCache_WrReq_Data(qd),
    .DCache_WrResp_Done(done), .DCache_WrResp_Ready(wrr),
    .Ld_Chk_Paddr(ck), .Ld_Chk_Hit(hit), .Sb_Empty(emp), .Sb_Count(cnt)
  );
  typedef struct {
    logic ev; logic [55:0] pa; logic [2:0] dt; logic [63:0] d; logic done; logic wrr; logic [55:0] ck;
    logic rdy; logic v; logic [55:0] qa; logic [2:0] qdt; logic [63:0] qd; logic hit; logic emp; logic [3:0] cnt;
  } vec_t;
  vec_t tv [17];
  logic [63:0] mq [$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input int hold, output logic [55:0] a, output logic [63:0] dd);
    int n = 0;
    while (!valid && n < 20) begin
      tick;
      n++;
    end
    chk("serve_valid_seen", 64'(valid), 1);
    a = qa;
    dd = qd;
    for (int i = 1; i < hold; i++) begin
      tick;
      chk("serve_hold_valid", 64'(valid), 1);
      chk("serve_hold_paddr", 64'(qa), 64'(a));
    end
    done = 1;
    tick;
    done = 0;
    chk("serve_retire_gap", 64'(valid), 0);
  endtask
  initial begin
    logic [55:0] a;
    logic [63:0] dd;
    int sent, popped, cyc;
    logic do_done;
    tv[0]  = '{1, 56'h1000, 3, 64'hA5A5, 0, 1, 56'h1000, 1, 0, 0, 0, 0, 1, 0, 1};
    tv[1]  = '{0, 0, 0, 0, 0, 1, 56'h1000, 1, 1, 56'h1000, 3, 64'hA5A5, 1, 0, 1};
    tv[2]  = tv[1];
    tv[3]  = tv[1];
    tv[4]  = tv[1];
    tv[5]  = '{0, 0, 0, 0, 1, 1, 56'h1000, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 1, 56'h1000, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[7]  = '{1, 56'h3004, 2, 64'h33, 0, 1, 56'h3000, 1, 0, 0, 0, 0, 1, 0, 1};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 56'h3008, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 56'h3007, 1, 0, 0, 0, 0, 1, 0, 1};
    tv[10] = '{0, 0, 0, 0, 0, 1, 56'h3000, 1, 1, 56'h3004, 2, 64'h33, 1, 0, 1};
    tv[11] = '{0, 0, 0, 0, 1, 1, 56'h3000, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[12] = '{0, 0, 0, 0, 0, 1, 56'h3000, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[13] = '{1, 56'h4000, 1, 64'h44, 1, 1, 56'h4000, 1, 0, 0, 0, 0, 1, 0, 1};
    tv[14] = '{0, 0, 0, 0, 1, 1, 56'h4000, 1, 1, 56'h4000, 1, 64'h44, 1, 0, 1};
    tv[15] = '{0, 0, 0, 0, 1, 1, 56'h4000, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[16] = '{0, 0, 0, 0, 0, 1, 56'h4000, 1, 0, 0, 0, 0, 0, 1, 0};
    repeat (2) tick;
    chk("rst_ready", 64'(rdy), 1);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_hit", 64'(hit), 0);
    chk("rst_empty", 64'(emp), 1);
    chk("rst_count", 64'(cnt), 0);
    chk("rst_paddr", 64'(qa), 0);
    chk("rst_dtype", 64'(qdt), 0);
    chk("rst_data", qd, 0);
    rst_n = 1;
    tick;
    for (int i = 0; i < 17; i++) begin
      ev = tv[i].ev; pa = tv[i].pa; dt = tv[i].dt; d = tv[i].d;
      done = tv[i].done; wrr = tv[i].wrr; ck = tv[i].ck;
      tick;
      chk($sformatf("v%0d_ready", i), 64'(rdy), 64'(tv[i].rdy));
      chk($sformatf("v%0d_valid", i), 64'(valid), 64'(tv[i].v));
      chk($sformatf("v%0d_paddr", i), 64'(qa), 64'(tv[i].qa));
      chk($sformatf("v%0d_dtype", i), 64'(qdt), 64'(tv[i].qdt));
      chk($sformatf("v%0d_data", i), qd, tv[i].d == 0 ? tv[i].qd : tv[i].qd);
      chk($sformatf("v%0d_hit", i), 64'(hit), 64'(tv[i].hit));
      chk($sformatf("v%0d_empty", i), 64'(emp), 64'(tv[i].emp));
      chk($sformatf("v%0d_count", i), 64'(cnt), 64'(tv[i].cnt));
    end
    ev = 0; done = 0; wrr = 1;
    // in-order issue with a Valid=0 gap; a same-cycle enqueue is not yet visible to the check
    ev = 1; pa = 56'h2000; d = 64'hAA; ck = 56'h2000;
    #1;
    chk("same_cycle_hit", 64'(hit), 0);
    tick;
    chk("next_cycle_hit", 64'(hit), 1);
    pa = 56'h2008; d = 64'hBB;
    tick;
    pa = 56'h2010; d = 64'hCC;
    tick;
    ev = 0;
    serve(2, a, dd);
    chk("order_a", 64'(a), 64'h2000);
    serve(2, a, dd);
    chk("order_b", 64'(a), 64'h2008);
    serve(2, a, dd);
    chk("order_c", 64'(a), 64'h2010);
    tick;
    chk("order_empty", 64'(emp), 1);
    // fill to full with Done withheld
    for (int i = 0; i < 8; i++) begin
      ev = 1; pa = 56'hA000 + 56'(i * 8); d = 64'hD0 + 64'(i);
      tick;
    end
    ev = 0;
    chk("full_count", 64'(cnt), 8);
    chk("full_ready", 64'(rdy), 0);
    ev = 1; pa = 56'hB000; d = 64'hDEAD;
    tick;
    chk("ninth_dropped_count", 64'(cnt), 8);
    chk("full_head_valid", 64'(valid), 1);
    chk("full_head_data", qd, 64'hD0);
    pa = 56'hB008; d = 64'hBEEF; done = 1;
    tick;
    ev = 0; done = 0;
    chk("full_pop_count", 64'(cnt), 7);
    chk("full_pop_ready", 64'(rdy), 1);
    for (int i = 1; i < 8; i++) begin
      serve(1, a, dd);
      chk($sformatf("drain_data%0d", i), dd, 64'hD0 + 64'(i));
    end
    tick;
    chk("drain_empty", 64'(emp), 1);
    chk("drain_count", 64'(cnt), 0);
    // pointer wrap against a queue model, occupancy kept at 3 or below
    sent = 0; popped = 0; cyc = 0;
    while (popped < 20 && cyc < 400) begin
      ev = sent < 20 && mq.size() < 3;
      pa = 56'h8000 + 56'(sent * 8);
      d = 64'hE000 + 64'(sent);
      do_done = valid && (cyc % 2 == 1);
      if (valid && mq.size() == 0) chk("wrap_spurious_valid", 64'(valid), 0);
      else if (do_done) chk($sformatf("wrap_order%0d", popped), qd, mq[0]);
      done = do_done;
      tick;
      if (do_done && mq.size() > 0) begin
        void'(mq.pop_front());
        popped++;
      end
      if (ev) begin
        mq.push_back(d);
        sent++;
      end
      chk("wrap_count", 64'(cnt), 64'(mq.size()));
      cyc++;
    end
    ev = 0; done = 0;
    chk("wrap_all_popped", 64'(popped), 20);
    // async reset while issuing with 5 pending entries
    for (int i = 0; i < 5; i++) begin
      ev = 1; pa = 56'h9000 + 56'(i * 8); d = 64'hF0 + 64'(i);
      tick;
    end
    ev = 0;
    for (int n = 0; n < 20 && !valid; n++) tick;
    chk("pre_reset_valid", 64'(valid), 1);
    chk("pre_reset_count", 64'(cnt), 5);
    ck = 56'h9000;
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(valid), 0);
    chk("async_rst_count", 64'(cnt), 0);
    repeat (2) tick;
    rst_n = 1;
    tick;
    chk("post_rst_ready", 64'(rdy), 1);
    chk("post_rst_empty", 64'(emp), 1);
    chk("post_rst_hit", 64'(hit), 0);
    chk("post_rst_valid", 64'(valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
